util_fft_mc: RTL
================

UTIL_FFT_MC -- requirements
Module: util_fft_mc

Interface
REQ-001 SHALL have parameters, one per line:
- FFT_SIZE_MAX, 4096, largest frame length
- INDX_WIDTH, 12, log2(FFT_SIZE_MAX)
- INPUT_WIDTH, 16, sink sample width per component
- OUTPUT_WIDTH, 16, source sample width per component
- CHANNELS, 4, interleaved channel count
- CH_WIDTH, 2, channel tag width
- TAG_DEPTH, 8, in-flight frame tag FIFO depth
REQ-002 SHALL have ports, one per line:
- clk, in, 1, clock, posedge active
- rst_n, in, 1, reset, asynchronous, active low
- cfg_size_log2, in, 4, frame length exponent
- inverse, in, 1, 0 = FFT, 1 = IFFT
- din_valid, in, 1, sink beat valid
- din_ready, out, 1, sink beat accepted
- din_real, in, INPUT_WIDTH, sink real component
- din_imag, in, INPUT_WIDTH, sink imaginary component
- core_sink_valid/sop/eop/inverse, out, 1 each, framed beat to FFT core
- core_sink_real/imag, out, INPUT_WIDTH, framed data to FFT core
- core_sink_ready, in, 1, FFT core can accept
- core_source_valid/sop/eop, in, 1 each, FFT core result framing
- core_source_real/imag, in, OUTPUT_WIDTH, FFT core result data
- core_source_exp, in, 6, block exponent
- core_source_ready, out, 1, result accepted
- dout_valid/sop/eop, out, 1 each, result framing
- dout_ready, in, 1, downstream can accept
- dout_real/imag, out, OUTPUT_WIDTH, result data
- dout_exp, out, 6, block exponent
- dout_index, out, INDX_WIDTH, bin index of current beat
- dout_channel, out, CH_WIDTH, channel tag of frame
- dout_inverse, out, 1, direction tag of frame
- frame_err_cnt, out, 16, source length error count
- tag_unf, out, 1, sticky tag FIFO underflow

Function
REQ-003 Init gate: rst_done SHALL rise on the 2nd clk edge after rst_n deasserts; din_ready SHALL stay 0 until then.
REQ-004 din_ready SHALL be core_sink_ready & rst_done & tag FIFO not full (combinational).
REQ-005 Accepted beat: din_valid & din_ready. core_sink_valid SHALL equal this, with data passed through combinationally.
REQ-006 Frame size SHALL be N = 2^cfg_size_log2, latched with inverse at each frame start (sink index 0 on an accepted beat).
REQ-007 cfg_size_log2 < 6 or > INDX_WIDTH SHALL clamp to FFT_SIZE_MAX.
REQ-008 Mid-frame changes to cfg_size_log2 or inverse SHALL NOT affect the current frame.
REQ-009 Sink index SHALL count accepted beats.
- core_sink_sop = accepted & index==0.
- core_sink_eop = accepted & index==N-1; index then wraps to 0.
REQ-010 core_sink_inverse SHALL be the live inverse at sop and the latched value afterwards.
REQ-011 Channel counter SHALL advance on each sink eop and wrap CHANNELS-1 -> 0.
REQ-012 Each sink sop SHALL push tag {channel, inverse, log2 N} into the TAG_DEPTH FIFO.
REQ-013 Source path SHALL be pass-through:
- dout_valid = core_source_valid.
- core_source_ready = dout_ready.
- dout_sop/eop/real/imag/exp = core values.
REQ-014 dout_channel, dout_inverse and the expected length SHALL come from the FIFO head; the head SHALL pop on an accepted source eop.
REQ-015 dout_index SHALL increment on each accepted source beat and reset to 0 after eop.
REQ-016 Accepted source eop with dout_index != N_head-1 SHALL increment frame_err_cnt, saturating at 0xFFFF.
REQ-017 Accepted source beat while the FIFO is empty SHALL set tag_unf, which holds until reset; the tag outputs then read 0.
REQ-018 Simultaneous push and pop SHALL both occur; occupancy is unchanged.
REQ-019 Full FIFO SHALL hold din_ready low only at a frame start; a frame in progress SHALL complete.

Reset
REQ-020 rst_n low SHALL asynchronously clear:
- all counters, rst_done, FIFO pointers, tag_unf, frame_err_cnt.
- din_ready and dout_index to 0.
- all registered outputs to 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; the first accepted beat after rst_done is sop, channel 0.

Verification
REQ-022 Release reset, hold din_valid=1 -> din_ready=0 for 2 cycles, then first accepted beat has core_sink_sop=1.
REQ-023 cfg_size_log2=6, 3 frames -> eop on beats 63/127/191; channels 0,1,2; 4th frame is channel 3; 5th frame is channel 0.
REQ-024 cfg_size_log2=3 -> frame length 4096 (clamped); change to 8 mid-frame -> current frame still 4096, next frame 256.
REQ-025 Core holds source ready off, 8 frames pushed -> din_ready=0 at the 9th sop; one pop -> accepted again.
REQ-026 Core emits source eop at index 100 with N=256 -> frame_err_cnt=1; source beat with empty FIFO -> tag_unf=1 until reset.

Source files
------------

// File: rtl/util_fft_mc.sv
// Framing and tag bookkeeping around a streaming FFT core: builds sop/eop on the
// sink side, carries per-frame channel/direction/length tags to the source side.
module util_fft_mc #(
    parameter int FFT_SIZE_MAX = 4096,
    parameter int INDX_WIDTH   = 12,
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int CHANNELS     = 4,
    parameter int CH_WIDTH     = 2,
    parameter int TAG_DEPTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              cfg_size_log2,
    input  logic                    inverse,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [INPUT_WIDTH-1:0]  din_real,
    input  logic [INPUT_WIDTH-1:0]  din_imag,
    output logic                    core_sink_valid,
    output logic                    core_sink_sop,
    output logic                    core_sink_eop,
    output logic                    core_sink_inverse,
    output logic [INPUT_WIDTH-1:0]  core_sink_real,
    output logic [INPUT_WIDTH-1:0]  core_sink_imag,
    input  logic                    core_sink_ready,
    input  logic                    core_source_valid,
    input  logic                    core_source_sop,
    input  logic                    core_source_eop,
    input  logic [OUTPUT_WIDTH-1:0] core_source_real,
    input  logic [OUTPUT_WIDTH-1:0] core_source_imag,
    input  logic [5:0]              core_source_exp,
    output logic                    core_source_ready,
    output logic                    dout_valid,
    output logic                    dout_sop,
    output logic                    dout_eop,
    input  logic                    dout_ready,
    output logic [OUTPUT_WIDTH-1:0] dout_real,
    output logic [OUTPUT_WIDTH-1:0] dout_imag,
    output logic [5:0]              dout_exp,
    output logic [INDX_WIDTH-1:0]   dout_index,
    output logic [CH_WIDTH-1:0]     dout_channel,
    output logic                    dout_inverse,
    output logic [15:0]             frame_err_cnt,
    output logic                    tag_unf
);

    localparam int TAG_W = CH_WIDTH + 1 + 4;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [3:0] MAX_LOG2 = 4'(INDX_WIDTH);
    localparam logic [INDX_WIDTH-1:0] ALL_ONES = '1;

    logic [1:0]            init_q;
    logic                  rst_done;
    logic [INDX_WIDTH-1:0] sink_idx;
    logic [3:0]            size_q;
    logic                  inv_q;
    logic [CH_WIDTH-1:0]   ch_cnt;
    logic [3:0]            cfg_clamped;
    logic [3:0]            cur_log2;
    logic [INDX_WIDTH-1:0] sink_last;
    logic                  frame_start;
    logic                  sink_acc;

    logic [TAG_W-1:0]      tag_mem [TAG_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  tag_push;
    logic                  tag_pop;
    logic [TAG_W-1:0]      head;
    logic [INDX_WIDTH-1:0] head_last;
    logic                  src_acc;

    // Two-flop gate: din_ready opens on the second edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_q <= 2'b00;
        else        init_q <= {init_q[0], 1'b1};
    end
    assign rst_done = init_q[1];

    always_comb begin
        cfg_clamped = cfg_size_log2;
        if (cfg_size_log2 < 4'd6 || cfg_size_log2 > MAX_LOG2) cfg_clamped = MAX_LOG2;
    end

    // At index 0 the live configuration applies; afterwards the latched copy.
    assign frame_start = (sink_idx == '0);
    assign cur_log2    = frame_start ? cfg_clamped : size_q;
    assign sink_last   = ALL_ONES >> (MAX_LOG2 - cur_log2);

    // A full tag FIFO only stalls the next frame start, never a frame in flight.
    assign din_ready = core_sink_ready & rst_done & (~fifo_full | ~frame_start);
    assign sink_acc  = din_valid & din_ready;

    assign core_sink_valid   = sink_acc;
    assign core_sink_sop     = sink_acc & frame_start;
    assign core_sink_eop     = sink_acc & (sink_idx == sink_last);
    assign core_sink_inverse = frame_start ? inverse : inv_q;
    assign core_sink_real    = din_real;
    assign core_sink_imag    = din_imag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sink_idx <= '0;
            size_q   <= '0;
            inv_q    <= 1'b0;
            ch_cnt   <= '0;
        end else if (sink_acc) begin
            sink_idx <= core_sink_eop ? '0 : sink_idx + 1'b1;
            if (frame_start) begin
                size_q <= cfg_clamped;
                inv_q  <= inverse;
            end
            if (core_sink_eop)
                ch_cnt <= (ch_cnt == CH_WIDTH'(CHANNELS - 1)) ? '0 : ch_cnt + 1'b1;
        end
    end

    // Tag FIFO, one entry per frame between sink sop and source eop.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign src_acc    = core_source_valid & dout_ready;
    assign tag_push   = core_sink_sop;
    assign tag_pop    = src_acc & core_source_eop & ~fifo_empty;
    assign head       = tag_mem[rd_ptr[PTR_W-1:0]];
    assign head_last  = ALL_ONES >> (MAX_LOG2 - head[3:0]);

    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[wr_ptr[PTR_W-1:0]] <= {ch_cnt, inverse, cfg_clamped};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (tag_push) wr_ptr <= wr_ptr + 1'b1;
            if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign dout_valid        = core_source_valid;
    assign core_source_ready = dout_ready;
    assign dout_sop          = core_source_sop;
    assign dout_eop          = core_source_eop;
    assign dout_real         = core_source_real;
    assign dout_imag         = core_source_imag;
    assign dout_exp          = core_source_exp;
    assign dout_channel      = fifo_empty ? '0 : head[TAG_W-1 -: CH_WIDTH];
    assign dout_inverse      = ~fifo_empty & head[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_index    <= '0;
            frame_err_cnt <= '0;
            tag_unf       <= 1'b0;
        end else if (src_acc) begin
            dout_index <= core_source_eop ? '0 : dout_index + 1'b1;
            if (core_source_eop && !fifo_empty && dout_index != head_last &&
                frame_err_cnt != 16'hFFFF)
                frame_err_cnt <= frame_err_cnt + 1'b1;
            if (fifo_empty) tag_unf <= 1'b1;
        end
    end

endmodule
